// File: rtl/phoenix_memory_arbiter_if.sv
// Bundle of the instruction port, data port and external memory signals around the arbiter.
// Core side: x_req is held with stable fields until the one-cycle x_ready pulse; the request is ignored during that pulse cycle. Memory side: mem_req is held with stable mem_* until a one-cycle mem_ack (or timeout).
interface phoenix_memory_arbiter_if;
   logic        i_req;
   logic        i_we;
   logic [31:0] i_addr;
   logic [3:0]  i_mask;
   logic [31:0] i_wdata;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_mask;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_mask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  i_req, i_we, i_addr, i_mask, i_wdata,
      input  d_req, d_we, d_addr, d_mask, d_wdata,
      input  mem_rdata, mem_ack,
      output i_rdata, i_ready, d_rdata, d_ready, err,
      output mem_req, mem_we, mem_addr, mem_mask, mem_wdata
   );

   modport master (
      output i_req, i_we, i_addr, i_mask, i_wdata,
      output d_req, d_we, d_addr, d_mask, d_wdata,
      output mem_rdata, mem_ack,
      input  i_rdata, i_ready, d_rdata, d_ready, err,
      input  mem_req, mem_we, mem_addr, mem_mask, mem_wdata
   );
endinterface

// File: rtl/phoenix_memory_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports.
// Data wins arbitration unless fetch has been starved STARVE_LIMIT times; accesses abort after TIMEOUT_CYCLES.
module phoenix_memory_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8,
   localparam int SW            = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   phoenix_memory_arbiter_if.slave bus,
   output logic [1:0]             dbg_state_o,
   output logic [SW-1:0]          dbg_starve_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_e;

   state_e         state_q, state_d;
   logic [SW-1:0]  starve_q, starve_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic           mem_req_q, mem_req_d;
   logic           mem_we_q, mem_we_d;
   logic [31:0]    mem_addr_q, mem_addr_d;
   logic [3:0]     mem_mask_q, mem_mask_d;
   logic [31:0]    mem_wdata_q, mem_wdata_d;
   logic           i_ready_q, i_ready_d;
   logic           d_ready_q, d_ready_d;
   logic [31:0]    i_rdata_q, i_rdata_d;
   logic [31:0]    d_rdata_q, d_rdata_d;
   logic           err_q, err_d;
   logic           i_eff, d_eff, pick_i, done, abort;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = '0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_mask_d  = mem_mask_q;
      mem_wdata_d = mem_wdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      i_rdata_d   = '0;
      d_rdata_d   = '0;
      err_d       = 1'b0;
      // A port completing this cycle still shows its old request; it must not be granted twice.
      i_eff       = bus.i_req & ~i_ready_q;
      d_eff       = bus.d_req & ~d_ready_q;
      pick_i      = 1'b0;
      done        = 1'b0;
      abort       = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_eff || d_eff) begin
               pick_i    = i_eff && (!d_eff || starve_q == SW'(STARVE_LIMIT));
               mem_req_d = 1'b1;
               if (pick_i) begin
                  state_d     = GRANT_I;
                  starve_d    = '0;
                  mem_we_d    = bus.i_we;
                  mem_addr_d  = bus.i_addr;
                  mem_mask_d  = bus.i_mask;
                  mem_wdata_d = bus.i_wdata;
               end else begin
                  state_d     = GRANT_D;
                  if (!bus.i_req) starve_d = '0;
                  else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = bus.d_addr;
                  mem_mask_d  = bus.d_mask;
                  mem_wdata_d = bus.d_wdata;
               end
            end
         end
         GRANT_I, GRANT_D: begin
            tmo_d = tmo_q + CNT_W'(1);
            done  = bus.mem_ack;
            abort = !bus.mem_ack && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
            if (done || abort) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               tmo_d     = '0;
               err_d     = abort;
               if (state_q == GRANT_I) begin
                  i_ready_d = 1'b1;
                  i_rdata_d = (done && !mem_we_q) ? bus.mem_rdata : 32'h0;
               end else begin
                  d_ready_d = 1'b1;
                  d_rdata_d = (done && !mem_we_q) ? bus.mem_rdata : 32'h0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_mask_q  <= '0;
         mem_wdata_q <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_mask_q  <= mem_mask_d;
         mem_wdata_q <= mem_wdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_mask  = mem_mask_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_ready   = i_ready_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.err       = err_q;
   assign dbg_state_o   = state_q;
   assign dbg_starve_o  = starve_q;

endmodule

// File: tb/tb_phoenix_memory_arbiter.sv
// Randomized bench for phoenix_memory_arbiter: transaction-level reference model plus memory responder.
module tb_phoenix_memory_arbiter;
   localparam int LIMIT = 2;
   localparam int TMO   = 16;
   localparam int PI    = 0;
   localparam int PD    = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] dbg_state;
   logic [1:0] dbg_starve;

   phoenix_memory_arbiter_if bus();

   phoenix_memory_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .dbg_state_o(dbg_state), .dbg_starve_o(dbg_starve)
   );

   always #5 clk = ~clk;

   typedef struct { int port; logic we; logic [3:0] mask; logic [31:0] wdata; int lat; } req_t;
   typedef struct { int port; int cyc; } rdy_t;

   req_t        req_map[logic [31:0]];
   logic [32:0] exp_i_q[$];
   logic [32:0] exp_d_q[$];
   int          exp_grant_q[$];
   rdy_t        exp_rdy_q[$];

   int   n_cmp = 0, n_bad = 0, cyc = 0, seq = 0;
   bit   chk_en = 1'b0;
   bit   acc_act = 1'b0;
   int   acc_cnt = 0;
   logic [31:0] acc_addr = '0;
   logic prev_mem_req = 1'b0;
   logic ack_next = 1'b0;
   bit   m_busy = 1'b0, m_rdy_i = 1'b0, m_rdy_d = 1'b0;
   int   m_port = 0, m_wait = 0, starve = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic issue(input int port, input logic we, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wdata, input int lat);
      req_t r;
      logic e;
      r.port = port; r.we = we; r.mask = mask; r.wdata = wdata; r.lat = lat;
      req_map[addr] = r;
      e = (lat >= TMO);
      if (port == PI) begin
         exp_i_q.push_back({e, (we || e) ? 32'h0 : mem_data(addr)});
         bus.i_we = we; bus.i_addr = addr; bus.i_mask = mask; bus.i_wdata = wdata; bus.i_req = 1'b1;
      end else begin
         exp_d_q.push_back({e, (we || e) ? 32'h0 : mem_data(addr)});
         bus.d_we = we; bus.d_addr = addr; bus.d_mask = mask; bus.d_wdata = wdata; bus.d_req = 1'b1;
      end
   endtask

   task automatic wait_ready(input int port);
      int  k;
      bit  seen;
      k = 0; seen = 1'b0;
      while (!seen && k < 300) begin
         @(negedge clk);
         k++;
         seen = (port == PI) ? bus.i_ready : bus.d_ready;
      end
      if (!seen) begin
         n_cmp++; n_bad++;
         $display("FAIL ready_wait: port %0d got no ready within 300 cycles, required one", port);
      end
      @(posedge clk); #1;
      if (port == PI) bus.i_req = 1'b0; else bus.d_req = 1'b0;
   endtask

   function automatic int pick_lat();
      int s;
      s = $urandom_range(0, 9);
      if (s == 0) return TMO;
      if (s == 1) return TMO - 1;
      return $urandom_range(1, 5);
   endfunction

   task automatic run_port(input int port, input int n);
      logic [31:0] a;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         a = 32'h1000 + (seq << 4) + (port << 2);
         seq++;
         issue(port, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, pick_lat());
         wait_ready(port);
      end
   endtask

   initial begin
      bus.mem_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.mem_ack = ack_next;
         bus.mem_rdata = ack_next ? mem_data(acc_addr) : $urandom;
      end
   end

   always @(negedge clk) begin
      bit   ie, de, nri, nrd;
      int   g;
      rdy_t rr;
      req_t r;
      logic [32:0] ex;
      cyc++;
      if (chk_en) begin
         check("mem_req_timing", bus.mem_req, m_busy);
         check("starve_cnt", dbg_starve, starve);
         if (bus.i_ready || bus.d_ready) begin
            check("ready_overlap", bus.i_ready && bus.d_ready, 0);
            if (exp_rdy_q.size() == 0) check("ready_unexpected", 1, 0);
            else begin
               rr = exp_rdy_q.pop_front();
               check("ready_port", bus.d_ready ? PD : PI, rr.port);
               check("ready_cycle", cyc, rr.cyc);
            end
         end else check("err_idle", bus.err, 0);
         if (bus.i_ready) begin
            if (exp_i_q.size() == 0) check("i_resp_unexpected", 1, 0);
            else begin ex = exp_i_q.pop_front(); check("i_resp_err_rdata", {bus.err, bus.i_rdata}, ex); end
         end else check("i_rdata_idle", bus.i_rdata, 0);
         if (bus.d_ready) begin
            if (exp_d_q.size() == 0) check("d_resp_unexpected", 1, 0);
            else begin ex = exp_d_q.pop_front(); check("d_resp_err_rdata", {bus.err, bus.d_rdata}, ex); end
         end else check("d_rdata_idle", bus.d_rdata, 0);

         // Memory responder: identify the access by address, then ack after its chosen latency.
         ack_next = 1'b0;
         if (bus.mem_req && !prev_mem_req) begin
            if (!req_map.exists(bus.mem_addr)) check("mem_addr_known", bus.mem_addr, 32'hFFFF_FFFF);
            else begin
               r = req_map[bus.mem_addr];
               check("mem_we", bus.mem_we, r.we);
               check("mem_mask", bus.mem_mask, r.mask);
               check("mem_wdata", bus.mem_wdata, r.wdata);
               if (exp_grant_q.size() == 0) check("grant_unexpected", 1, 0);
               else check("grant_port", r.port, exp_grant_q.pop_front());
               acc_act = 1'b1; acc_cnt = r.lat; acc_addr = bus.mem_addr;
            end
         end else if (bus.mem_req) check("mem_addr_hold", bus.mem_addr, acc_addr);
         if (acc_act) begin
            acc_cnt--;
            if (acc_cnt == 0) begin ack_next = 1'b1; acc_act = 1'b0; end
         end
         prev_mem_req = bus.mem_req;

         // Reference arbitration: one access at a time, data first, forced fetch after LIMIT starved grants.
         ie = bus.i_req && !m_rdy_i;
         de = bus.d_req && !m_rdy_d;
         nri = 1'b0; nrd = 1'b0;
         if (!m_busy) begin
            if (ie || de) begin
               g = (de && !(ie && starve == LIMIT)) ? PD : PI;
               if (g == PD) starve = bus.i_req ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
               else starve = 0;
               exp_grant_q.push_back(g);
               m_busy = 1'b1; m_port = g; m_wait = 0;
            end
         end else begin
            m_wait++;
            if (bus.mem_ack || m_wait == TMO) begin
               m_busy = 1'b0;
               exp_rdy_q.push_back('{port: m_port, cyc: cyc + 1});
               if (m_port == PI) nri = 1'b1; else nrd = 1'b1;
            end
         end
         m_rdy_i = nri; m_rdy_d = nrd;
      end
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      bus.i_req = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_mask = 0; bus.i_wdata = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_mask = 0; bus.d_wdata = 0;
      bus.mem_rdata = 0;
      repeat (3) @(negedge clk);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_mask", bus.mem_mask, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_ready", {bus.i_ready, bus.d_ready, bus.err}, 0);
      check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      check("rst_starve", dbg_starve, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      issue(PD, 1'b0, 32'h100, 4'hF, 32'h0, 3);          wait_ready(PD);
      issue(PD, 1'b1, 32'h200, 4'b1000, 32'h0000_00AA, 2); wait_ready(PD);
      issue(PD, 1'b0, 32'h300, 4'hF, 32'h0, TMO);        wait_ready(PD);
      issue(PI, 1'b0, 32'h400, 4'hF, 32'h0, 1);
      issue(PD, 1'b0, 32'h410, 4'h3, 32'h0, 1);
      fork
         wait_ready(PI);
         wait_ready(PD);
      join

      fork
         run_port(PI, 40);
         run_port(PD, 40);
      join
      repeat (5) @(negedge clk);
      check("drain_queues", exp_i_q.size() + exp_d_q.size() + exp_grant_q.size() + exp_rdy_q.size(), 0);

      @(posedge clk); #1;
      issue(PI, 1'b0, 32'h500, 4'hF, 32'h0, TMO);
      begin
         int k;
         k = 0;
         while (!bus.mem_req && k < 10) begin @(negedge clk); k++; end
         check("rst_test_grant", bus.mem_req, 1);
      end
      @(posedge clk); #2;
      chk_en = 1'b0;
      reset = 1'b0;
      bus.i_req = 1'b0;
      #1;
      check("async_rst_mem_req", bus.mem_req, 0);
      check("async_rst_ready", {bus.i_ready, bus.d_ready}, 0);
      exp_i_q.delete(); exp_d_q.delete(); exp_grant_q.delete(); exp_rdy_q.delete();
      acc_act = 1'b0; ack_next = 1'b0; prev_mem_req = 1'b0;
      m_busy = 1'b0; m_rdy_i = 1'b0; m_rdy_d = 1'b0; starve = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_no_i_ready", bus.i_ready, 0);
         check("post_rst_mem_req", bus.mem_req, 0);
      end
      check("post_rst_starve", dbg_starve, 0);
      check("post_rst_idle", dbg_state, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
